// File: rtl/qsfp_link_pkg.sv
// Shared types and constants for the QSFP28 cage power-up / link sequencer.
package qsfp_link_pkg;

  // Sequencer states; the encoding is visible to software through status[2:0].
  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_REFCLK_RST = 3'd1,
    ST_MOD_RST    = 3'd2,
    ST_MOD_INIT   = 3'd3,
    ST_WAIT_GT    = 3'd4,
    ST_UP         = 3'd5
  } link_state_e;

  // Bit positions inside the 16-bit status word.
  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_PRESENT   = 3;
  localparam int STAT_INT       = 4;
  localparam int STAT_CLOCK_OK  = 5;
  localparam int STAT_RETRY_LSB = 8;
  localparam int STAT_DROP_LSB  = 12;

  // Default timing at 125 MHz.
  localparam int DEF_DEBOUNCE_CYCLES   = 1024;
  localparam int DEF_REFCLK_RST_CYCLES = 256;
  localparam int DEF_MOD_RST_CYCLES    = 2000;
  localparam int DEF_MOD_INIT_CYCLES   = 250000000;
  localparam int DEF_GT_TIMEOUT_CYCLES = 12500000;
  localparam int DEF_CNT_W             = 32;

  // 4-bit event counter that sticks at 15 instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/qsfp_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for one
// asynchronous, active-high module sideband level.
module qsfp_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic db_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic [CW-1:0] cnt_q;

  // Bring the pin into the clock domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES in a row;
  // any return to the old level restarts the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else if (sync2_q != db_q) begin
      if (cnt_q == LAST) begin
        db_q  <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/qsfp_link_ctrl.sv
// Power-up and link sequencer for one QSFP28 cage: drives the module
// sideband pins, sequences refclk/module reset and init, waits for GT ready
// and reports status and interrupts to the SoC.
module qsfp_link_ctrl
  import qsfp_link_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int REFCLK_RST_CYCLES = DEF_REFCLK_RST_CYCLES,
  parameter int MOD_RST_CYCLES    = DEF_MOD_RST_CYCLES,
  parameter int MOD_INIT_CYCLES   = DEF_MOD_INIT_CYCLES,
  parameter int GT_TIMEOUT_CYCLES = DEF_GT_TIMEOUT_CYCLES,
  parameter int CNT_W             = DEF_CNT_W
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cfg_enable_i,
  input  logic [1:0]  cfg_fs_i,
  input  logic        cfg_lpmode_i,
  input  logic        irq_ack_i,
  input  logic        gt_ready_i,
  input  logic        qsfp_modprsl_i,
  input  logic        qsfp_intl_i,
  output logic        qsfp_modsell_o,
  output logic        qsfp_resetl_o,
  output logic        qsfp_lpmode_o,
  output logic        qsfp_refclk_reset_o,
  output logic [1:0]  qsfp_fs_o,
  output logic        clock_ok_o,
  output logic        irq_o,
  output logic [15:0] status_o
);

  // Timer reload values: the timer counts down to zero, so a state lasts load+1 cycles.
  localparam logic [CNT_W-1:0] REFCLK_LOAD = CNT_W'(REFCLK_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] MOD_RST_LOAD = CNT_W'(MOD_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] MOD_INIT_LOAD = CNT_W'(MOD_INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GT_LOAD = CNT_W'(GT_TIMEOUT_CYCLES - 1);

  logic present_db, int_db;

  // Both pins are active low; debounce the asserted (active-high) sense.
  qsfp_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_present (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .async_i(~qsfp_modprsl_i),
    .db_o   (present_db)
  );

  qsfp_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_int (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .async_i(~qsfp_intl_i),
    .db_o   (int_db)
  );

  link_state_e      state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, timer_load;
  logic [1:0]       fs_q, fs_d;
  logic [3:0]       retry_q, retry_d, drop_q, drop_d;
  logic             irq_q, irq_d;
  logic             present_prev_q, int_prev_q;
  logic             modsell_q, resetl_q, lpmode_q, refclk_rst_q, clock_ok_q;
  logic             reload, timeout, irq_set;

  // Next-state logic: OFF override first, then fs relatch, then the normal sequence.
  always_comb begin
    state_d = state_q;
    fs_d    = fs_q;
    retry_d = retry_q;
    drop_d  = drop_q;
    reload  = 1'b0;
    timeout = 1'b0;
    if (!present_db || !cfg_enable_i) begin
      state_d = ST_OFF;
    end else if (state_q != ST_OFF && cfg_fs_i != fs_q) begin
      state_d = ST_REFCLK_RST;
      fs_d    = cfg_fs_i;
      reload  = 1'b1;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_REFCLK_RST;
          fs_d    = cfg_fs_i;
          reload  = 1'b1;
        end
        ST_REFCLK_RST: if (timer_q == '0) begin
          state_d = ST_MOD_RST;
          reload  = 1'b1;
        end
        ST_MOD_RST: if (timer_q == '0) begin
          state_d = ST_MOD_INIT;
          reload  = 1'b1;
        end
        ST_MOD_INIT: if (timer_q == '0) begin
          state_d = ST_WAIT_GT;
          reload  = 1'b1;
        end
        ST_WAIT_GT: begin
          if (gt_ready_i) begin
            state_d = ST_UP;
            reload  = 1'b1;
          end else if (timer_q == '0) begin
            state_d = ST_REFCLK_RST;
            retry_d = sat_inc4(retry_q);
            timeout = 1'b1;
            reload  = 1'b1;
          end
        end
        ST_UP: if (!gt_ready_i) begin
          state_d = ST_WAIT_GT;
          drop_d  = sat_inc4(drop_q);
          reload  = 1'b1;
        end
        default: state_d = ST_OFF;
      endcase
    end
    if (state_d == ST_OFF) begin
      retry_d = 4'd0;
      drop_d  = 4'd0;
    end
  end

  // Timer reload value for the state being entered; untimed states load zero.
  always_comb begin
    timer_load = '0;
    case (state_d)
      ST_REFCLK_RST: timer_load = REFCLK_LOAD;
      ST_MOD_RST:    timer_load = MOD_RST_LOAD;
      ST_MOD_INIT:   timer_load = MOD_INIT_LOAD;
      ST_WAIT_GT:    timer_load = GT_LOAD;
      default:       timer_load = '0;
    endcase
    if (reload)              timer_d = timer_load;
    else if (timer_q == '0)  timer_d = timer_q;
    else                     timer_d = timer_q - CNT_W'(1);
  end

  // Interrupt: any set source beats a same-cycle acknowledge.
  always_comb begin
    irq_set = (int_db & ~int_prev_q) | (present_db ^ present_prev_q) | timeout;
    if (irq_set)        irq_d = 1'b1;
    else if (irq_ack_i) irq_d = 1'b0;
    else                irq_d = irq_q;
  end

  // Sequencer registers; pin outputs are decoded from the next state so they
  // change on the same edge as the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_OFF;
      timer_q        <= '0;
      fs_q           <= 2'b00;
      retry_q        <= 4'd0;
      drop_q         <= 4'd0;
      irq_q          <= 1'b0;
      present_prev_q <= 1'b0;
      int_prev_q     <= 1'b0;
      modsell_q      <= 1'b1;
      resetl_q       <= 1'b0;
      lpmode_q       <= 1'b1;
      refclk_rst_q   <= 1'b1;
      clock_ok_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      fs_q           <= fs_d;
      retry_q        <= retry_d;
      drop_q         <= drop_d;
      irq_q          <= irq_d;
      present_prev_q <= present_db;
      int_prev_q     <= int_db;
      modsell_q      <= !(state_d inside {ST_WAIT_GT, ST_UP});
      resetl_q       <= state_d inside {ST_MOD_INIT, ST_WAIT_GT, ST_UP};
      lpmode_q       <= (state_d inside {ST_WAIT_GT, ST_UP}) ? cfg_lpmode_i : 1'b1;
      refclk_rst_q   <= state_d inside {ST_OFF, ST_REFCLK_RST};
      clock_ok_q     <= (state_d == ST_UP);
    end
  end

  // Assemble the software-visible status word.
  always_comb begin
    status_o = '0;
    status_o[STAT_STATE_LSB +: 3] = state_q;
    status_o[STAT_PRESENT]        = present_db;
    status_o[STAT_INT]            = int_db;
    status_o[STAT_CLOCK_OK]       = clock_ok_q;
    status_o[STAT_RETRY_LSB +: 4] = retry_q;
    status_o[STAT_DROP_LSB +: 4]  = drop_q;
  end

  assign qsfp_modsell_o      = modsell_q;
  assign qsfp_resetl_o       = resetl_q;
  assign qsfp_lpmode_o       = lpmode_q;
  assign qsfp_refclk_reset_o = refclk_rst_q;
  assign qsfp_fs_o           = fs_q;
  assign clock_ok_o          = clock_ok_q;
  assign irq_o               = irq_q;

endmodule

// File: doc/qsfp_link_ctrl.md
Name: qsfp_link_ctrl

Overview:
Power-up and link sequencer for one QSFP28 cage feeding the 10G SFP Ethernet PHY block.
- Drives module sideband pins: ModSelL, ResetL, LPMode, refclk synthesizer reset, FS[1:0].
- Debounces ModPrsL and IntL.
- Sequences refclk reset, module reset and module init, then waits for GT ready.
- Generates clock_ok for the PHY's initialization logic and reports status/interrupt to the RISC-V SoC.

Parameters:
- DEBOUNCE_CYCLES, 1024: stable-input cycles required before a debounced ModPrsL/IntL change is accepted.
- REFCLK_RST_CYCLES, 256: cycles refclk_reset is held high.
- MOD_RST_CYCLES, 2000: cycles ResetL is held low (>10 us at 125 MHz).
- MOD_INIT_CYCLES, 250000000: module t_init wait after ResetL release.
- GT_TIMEOUT_CYCLES, 12500000: maximum wait for gt_ready before retry.
- CNT_W, 32: timer width; must hold the largest *_CYCLES value.

Ports:
- clock in 1: single clock for the whole block.
- resetn in 1: asynchronous active-low reset.
- cfg_enable in 1: 1 = bring link up, 0 = force OFF.
- cfg_fs in 2: refclk frequency select to apply.
- cfg_lpmode in 1: requested LPMode level while UP.
- irq_ack in 1: single-cycle pulse that clears irq.
- gt_ready in 1: GT/PHY reset-done, synchronous to clock.
- qsfp_modprsl in 1: module present (active low), asynchronous.
- qsfp_intl in 1: module interrupt (active low), asynchronous.
- qsfp_modsell out 1: module select (active low).
- qsfp_resetl out 1: module reset (active low).
- qsfp_lpmode out 1: module low-power mode.
- qsfp_refclk_reset out 1: refclk synthesizer reset.
- qsfp_fs out 2: refclk frequency select.
- clock_ok out 1: PHY clocks valid; drives PHY init.
- irq out 1: level interrupt.
- status out 16: [2:0] state, [3] present_db, [4] int_db, [5] clock_ok, [11:8] retry_cnt, [15:12] drop_cnt.

Behaviour:
- Reset values:
  - modsell=1, resetl=0, lpmode=1, refclk_reset=1, fs=2'b00.
  - clock_ok=0, irq=0, status=0.
  - state=OFF, all counters=0; present_db=0, int_db=0.
- Input conditioning:
  - ModPrsL and IntL each pass through a 2-FF synchronizer, then a debouncer.
  - The debounced value updates after the synchronized input has been stable and different for DEBOUNCE_CYCLES consecutive cycles, i.e. DEBOUNCE_CYCLES+2 cycles after a raw change.
  - A glitch shorter than that restarts the count and produces no change.
- FSM (one timer, reloaded on every state entry; each timed state lasts exactly its *_CYCLES):
  - OFF: refclk_reset=1, resetl=0, lpmode=1, modsell=1, clock_ok=0. Go to REFCLK_RST the cycle after present_db && cfg_enable. cfg_fs is latched into qsfp_fs on that transition.
  - REFCLK_RST: refclk_reset=1, resetl=0. On expiry go to MOD_RST.
  - MOD_RST: refclk_reset=0, resetl=0. On expiry go to MOD_INIT.
  - MOD_INIT: resetl=1, lpmode=1. On expiry go to WAIT_GT.
  - WAIT_GT: modsell=0, lpmode=cfg_lpmode.
    - gt_ready=1: go to UP, clock_ok=1 from the next cycle.
    - Timeout: retry_cnt++ (saturates at 15), go to REFCLK_RST.
  - UP: clock_ok=1, lpmode follows cfg_lpmode (1-cycle register).
    - gt_ready=0: clock_ok=0 next cycle, drop_cnt++ (saturating), go to WAIT_GT.
- Global overrides, any state:
  - present_db=0 or cfg_enable=0: go to OFF next cycle. This has priority over every other transition, including a simultaneous timer expiry.
  - cfg_fs differs from the latched fs while in a state other than OFF: go to REFCLK_RST and relatch fs. This has lower priority than the OFF override.
- retry_cnt and drop_cnt clear only on resetn or on entering OFF.
- irq:
  - Set on a rising edge of int_db (IntL asserted), any change of present_db, or a WAIT_GT timeout.
  - Cleared by irq_ack. If a set condition and irq_ack occur in the same cycle, set wins.
- Asynchronous resetn mid-sequence: all outputs return to their reset values immediately; no pending transition is preserved.

Decomposition:
- Package qsfp_link_pkg:
  - State encoding: OFF=0, REFCLK_RST=1, MOD_RST=2, MOD_INIT=3, WAIT_GT=4, UP=5.
  - Status bit-position constants.
  - Default cycle constants.
- Sub-module qsfp_debounce (sync + debounce, parameter DEBOUNCE_CYCLES), instantiated twice (ModPrsL, IntL).
- FSM, timer and counters live in qsfp_link_ctrl.

Test Plan:
Bench parameters: DEBOUNCE=4, REFCLK_RST=8, MOD_RST=16, MOD_INIT=32, GT_TIMEOUT=64.
- Bring-up: resetn release, modprsl=0, cfg_enable=1, cfg_fs=2'b10, gt_ready rises 10 cycles into WAIT_GT.
  - Required: refclk_reset high for 8 cycles, then resetl low for 16 more, then resetl=1 for 32.
  - Then modsell=0; clock_ok=1 one cycle after gt_ready; fs=2'b10; status[2:0]=5.
- GT timeout: gt_ready held 0.
  - Required: WAIT_GT lasts 64 cycles, then REFCLK_RST re-entered, retry_cnt=1, irq=1.
  - After 16 timeouts, retry_cnt stays at 15.
- Module removal in UP: modprsl=1 held.
  - Required: state OFF and clock_ok=0 within 4+2+1 cycles; resetl=0, lpmode=1, irq=1.
  - A 3-cycle modprsl pulse causes no state change.
- Link drop and simultaneous events:
  - gt_ready 1→0 in UP: clock_ok=0 next cycle, drop_cnt=1.
  - irq_ack in the same cycle as an IntL debounced assertion: irq remains 1.
- FS change and async reset:
  - cfg_fs 2'b10→2'b01 in UP: re-enter REFCLK_RST, qsfp_fs=2'b01.
  - resetn asserted mid-MOD_INIT: outputs take reset values without waiting for a clock edge.
